aes_round_ctrl: RTL and testbench

Iterative AES-128 encryption sequencer that sits directly upstream of the single-round AES core. It accepts a plaintext/cipher-key pair over a valid/ready handshake and performs the initial AddRoundKey. It then drives the round core through rounds 0–9, feeding each round's text and round key back as the next round's input. When round 9 completes, it presents the ciphertext on a valid/ready output port.

---
 rtl/aes_round_ctrl_if.sv | 43 ++++
 rtl/aes_round_ctrl.sv | 109 ++++++++++
 tb/tb_aes_round_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_round_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : aes_round_ctrl_if
// Description : Block-in, ciphertext-out and round-core bundle for aes_round_ctrl.
//               AES_CTRL_LASTKEY_EN adds out_key (final round key).
// Revision    : 1.0
// ============================================================================
interface aes_round_ctrl_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_text;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_text;
`ifdef AES_CTRL_LASTKEY_EN
    logic [127:0] out_key;
`endif
    logic         rc_enable;
    logic [127:0] rc_text;
    logic [127:0] rc_key;
    logic [3:0]   rc_round;
    logic [127:0] rc_text_in;
    logic [127:0] rc_key_in;
    logic         rc_done;

    modport slave (
        input  in_valid, in_text, in_key, out_ready, rc_text_in, rc_key_in, rc_done,
        output in_ready, out_valid, out_text, rc_enable, rc_text, rc_key, rc_round
`ifdef AES_CTRL_LASTKEY_EN
        , output out_key
`endif
    );

    modport master (
        output in_valid, in_text, in_key, out_ready, rc_text_in, rc_key_in, rc_done,
        input  in_ready, out_valid, out_text, rc_enable, rc_text, rc_key, rc_round
`ifdef AES_CTRL_LASTKEY_EN
        , input out_key
`endif
    );
endinterface
`default_nettype wire

// File: rtl/aes_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : aes_round_ctrl
// Description : Iterative AES-128 sequencer driving a single-round core.
//               Optional AES_CTRL_LASTKEY_EN exports the final round key.
// Revision    : 1.0
// ============================================================================
module aes_round_ctrl #(
    parameter int NROUNDS = 10
) (
    input  wire logic        clock,
    input  wire logic        resetn,
    aes_round_ctrl_if.slave  bus,
    output logic             busy
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    localparam logic [3:0] c_LAST_RND = 4'(NROUNDS - 1);

    state_t       r_state;
    state_t       w_state_nxt;
    logic [127:0] r_st_text;
    logic [127:0] r_st_key;
    logic [3:0]   r_rnd;
    logic         w_load;
    logic         w_capture;
    logic         w_last;

    assign w_load    = (r_state == S_IDLE) && bus.in_valid;
    assign w_capture = (r_state == S_WAIT) && bus.rc_done;
    assign w_last    = (r_rnd == c_LAST_RND);

    assign bus.rc_text  = r_st_text;
    assign bus.rc_key   = r_st_key;
    assign bus.rc_round = r_rnd;
    assign bus.out_text = r_st_text;
`ifdef AES_CTRL_LASTKEY_EN
    assign bus.out_key  = r_st_key;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // All outputs decode the state register only, so nothing is combinational from inputs.
    always_comb begin
        w_state_nxt   = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.rc_enable = 1'b0;
        busy          = 1'b1;
        case (r_state)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                busy         = 1'b0;
                if (bus.in_valid) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                bus.rc_enable = 1'b1;
                w_state_nxt   = S_WAIT;
            end
            S_WAIT: begin
                if (bus.rc_done) begin
                    w_state_nxt = w_last ? S_OUT : S_START;
                end
            end
            S_OUT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Initial AddRoundKey happens on load; each round result is fed straight back.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_st_text <= '0;
            r_st_key  <= '0;
            r_rnd     <= '0;
        end else if (w_load) begin
            r_st_text <= bus.in_text ^ bus.in_key;
            r_st_key  <= bus.in_key;
            r_rnd     <= '0;
        end else if (w_capture) begin
            r_st_text <= bus.rc_text_in;
            r_st_key  <= bus.rc_key_in;
            if (!w_last) begin
                r_rnd <= r_rnd + 4'd1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_aes_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_round_ctrl
// Description : Scoreboard bench for aes_round_ctrl with a behavioural AES round core.
// Revision    : 1.0
// ============================================================================
module tb_aes_round_ctrl;
    localparam logic [127:0] c_C1_PT = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [127:0] c_C1_K  = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] c_C1_CT = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
    localparam logic [127:0] c_C1_LK = 128'hc5302b4d8ba707f3174a94e37f1d1113;
    localparam logic [127:0] c_B_PT  = 128'h340737e0a29831318d305a88a8f64332;
    localparam logic [127:0] c_B_K   = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
    localparam logic [127:0] c_B_CT  = 128'h320b6a19978511dcfb09dc021d842539;
    localparam logic [127:0] c_B_LK  = 128'ha60c63b6c80c3fe18925eec9a8f914d0;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    logic busy;
    aes_round_ctrl_if bus();

    aes_round_ctrl #(.NROUNDS(10)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus.slave),
        .busy   (busy)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic [127:0] exp_q[$];
    logic [127:0] expk_q[$];
    int acc_q[$];
    int acc_log[$];

    function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", nm, act, req);
        end
    endfunction

    function automatic void chki(input string nm, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", nm, act, req);
        end
    endfunction

    function automatic void tmo(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: actual timeout required event", nm);
    endfunction

    // ---------------- AES reference arithmetic ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] v = 8'h01;
        for (int i = 0; i < 254; i++) v = gmul(v, a);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] key_next(input logic [127:0] k, input int r);
        logic [7:0]  rcon = 8'h01;
        logic [31:0] t, n0, n1, n2, n3;
        for (int i = 0; i < r; i++) rcon = xt(rcon);
        t  = {sbox(k[103:96]), sbox(k[127:120]), sbox(k[119:112]), sbox(k[111:104])};
        t[7:0] = t[7:0] ^ rcon;
        n0 = k[31:0] ^ t;
        n1 = k[63:32] ^ n0;
        n2 = k[95:64] ^ n1;
        n3 = k[127:96] ^ n2;
        return {n3, n2, n1, n0};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] t, input logic [127:0] k, input int r);
        logic [7:0] s [16];
        logic [7:0] sr[16];
        logic [7:0] m [16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) s[i] = sbox(t[8*i +: 8]);
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++) sr[w + 4*c] = s[w + 4*((c + w) % 4)];
        for (int c = 0; c < 4; c++) begin
            m[4*c]   = xt(sr[4*c]) ^ xt(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
            m[4*c+1] = sr[4*c] ^ xt(sr[4*c+1]) ^ xt(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
            m[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xt(sr[4*c+2]) ^ xt(sr[4*c+3]) ^ sr[4*c+3];
            m[4*c+3] = xt(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xt(sr[4*c+3]);
        end
        for (int i = 0; i < 16; i++) o[8*i +: 8] = ((r == 9) ? sr[i] : m[i]) ^ k[8*i +: 8];
        return o;
    endfunction

    // ---------------- round core model (enable sampled at count 0, done 20 edges later) ----------------
    logic         core_done;
    logic         inj_done = 1'b0;
    int           core_cnt;
    int           core_r;
    logic [127:0] core_t, core_k, lat_t, lat_k;

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            core_cnt  <= 0;
            core_done <= 1'b0;
            core_t    <= '0;
            core_k    <= '0;
            lat_t     <= '0;
            lat_k     <= '0;
            core_r    <= 0;
        end else begin
            core_done <= 1'b0;
            if (core_cnt == 0) begin
                if (bus.rc_enable) begin
                    core_cnt <= 1;
                    lat_t    <= bus.rc_text;
                    lat_k    <= bus.rc_key;
                    core_r   <= int'(bus.rc_round);
                end
            end else if (core_cnt == 20) begin
                core_cnt  <= 0;
                core_done <= 1'b1;
                core_k    <= key_next(lat_k, core_r);
                core_t    <= aes_round(lat_t, key_next(lat_k, core_r), core_r);
            end else begin
                core_cnt <= core_cnt + 1;
            end
        end
    end

    assign bus.rc_done    = core_done | inj_done;
    assign bus.rc_text_in = core_t;
    assign bus.rc_key_in  = core_k;

    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- monitor ----------------
    logic prev_ov  = 1'b0;
    logic unstable = 1'b0;
    int   en_cnt   = 0;
    int   last_en  = 0;

    always @(negedge clock) begin
        if (!resetn) begin
            prev_ov  = 1'b0;
            unstable = 1'b0;
            en_cnt   = 0;
        end else begin
            if (bus.in_valid && bus.in_ready) begin
                acc_q.push_back(cyc + 1);
                acc_log.push_back(cyc + 1);
                en_cnt = 0;
            end
            if (bus.rc_enable) begin
                chki("rc_round_seq", int'(bus.rc_round), en_cnt);
                if (en_cnt > 0) chki("rc_enable_spacing", cyc - last_en, 22);
                en_cnt++;
                last_en = cyc;
            end
            if (core_cnt != 0 && (bus.rc_text !== lat_t || bus.rc_key !== lat_k)) unstable = 1'b1;
            if (core_done) begin
                chki("rc_inputs_stable", int'(unstable), 0);
                unstable = 1'b0;
            end
            if (bus.out_valid && !prev_ov) begin
                chki("rc_enable_count", en_cnt, 10);
                if (acc_q.size() == 0) tmo("out_valid_without_accept");
                else chki("out_valid_latency", cyc - acc_q.pop_front(), 220);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    tmo("unexpected_output");
                end else begin
                    chk("out_text", bus.out_text, exp_q.pop_front());
`ifdef AES_CTRL_LASTKEY_EN
                    chk("out_key", bus.out_key, expk_q.pop_front());
`else
                    void'(expk_q.pop_front());
`endif
                end
            end
            prev_ov = bus.out_valid;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [127:0] t, input logic [127:0] k,
                        input logic [127:0] ct, input logic [127:0] lk);
        int g = 0;
        bus.in_valid = 1'b1;
        bus.in_text  = t;
        bus.in_key   = k;
        exp_q.push_back(ct);
        expk_q.push_back(lk);
        while (!bus.in_ready && g < 500) begin
            tick();
            g++;
        end
        if (g >= 500) tmo("send_in_ready");
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int g = 0;
        while (busy && g < 600) begin
            tick();
            g++;
        end
        if (g >= 600) tmo(nm);
    endtask

    initial begin
        logic [127:0] t0, k0, ot;
        logic [3:0]   r0;
        logic         f_ov, f_ot, f_ir;
        int           g;

        bus.in_valid  = 1'b0;
        bus.in_text   = '0;
        bus.in_key    = '0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_rc_enable", bus.rc_enable, 1'b0);
        chk("rst_rc_text", bus.rc_text, '0);
        chk("rst_rc_round", bus.rc_round, '0);
        resetn = 1'b1;
        tick();
        chk("rst_in_ready", bus.in_ready, 1'b1);

        // FIPS-197 C.1 with the consumer always ready
        send(c_C1_PT, c_C1_K, c_C1_CT, c_C1_LK);
        wait_idle("c1_timeout");

        // Spurious rc_done while idle
        t0 = bus.rc_text;
        k0 = bus.rc_key;
        r0 = bus.rc_round;
        inj_done = 1'b1;
        tick();
        inj_done = 1'b0;
        tick();
        chk("idle_spur_busy", busy, 1'b0);
        chk("idle_spur_rc_text", bus.rc_text, t0);
        chk("idle_spur_rc_key", bus.rc_key, k0);
        chk("idle_spur_rc_round", bus.rc_round, r0);
        chk("idle_spur_rc_enable", bus.rc_enable, 1'b0);

        // Output backpressure, with an ignored in_valid pulse and a spurious rc_done in OUT
        bus.out_ready = 1'b0;
        send(c_B_PT, c_B_K, c_B_CT, c_B_LK);
        g = 0;
        while (!bus.out_valid && g < 400) begin
            tick();
            g++;
        end
        if (g >= 400) tmo("bp_out_valid");
        ot   = bus.out_text;
        f_ov = 1'b0;
        f_ot = 1'b0;
        f_ir = 1'b0;
        bus.in_text = 128'hdeadbeefcafef00d0123456789abcdef;
        for (int i = 0; i < 50; i++) begin
            bus.in_valid = (i == 10);
            inj_done     = (i == 20);
            tick();
            if (!bus.out_valid) f_ov = 1'b1;
            if (bus.out_text !== ot) f_ot = 1'b1;
            if (bus.in_ready) f_ir = 1'b1;
        end
        bus.in_valid = 1'b0;
        inj_done     = 1'b0;
        chk("bp_out_valid_drop", f_ov, 1'b0);
        chk("bp_out_text_change", f_ot, 1'b0);
        chk("bp_in_ready_high", f_ir, 1'b0);
        chk("bp_out_text", bus.out_text, c_B_CT);
        chk("bp_rc_round", bus.rc_round, 4'd9);
        bus.out_ready = 1'b1;
        tick();
        chk("bp_release_busy", busy, 1'b0);
        chk("bp_release_in_ready", bus.in_ready, 1'b1);

        // Back-to-back: in_valid held high across two queued blocks
        acc_log.delete();
        exp_q.push_back(c_C1_CT);
        expk_q.push_back(c_C1_LK);
        exp_q.push_back(c_B_CT);
        expk_q.push_back(c_B_LK);
        bus.in_valid = 1'b1;
        bus.in_text  = c_C1_PT;
        bus.in_key   = c_C1_K;
        tick();
        bus.in_text = c_B_PT;
        bus.in_key  = c_B_K;
        g = 0;
        while (!bus.in_ready && g < 400) begin
            tick();
            g++;
        end
        if (g >= 400) tmo("b2b_second_accept");
        tick();
        bus.in_valid = 1'b0;
        wait_idle("b2b_timeout");
        if (acc_log.size() != 2) chki("b2b_accept_count", acc_log.size(), 2);
        else chki("b2b_accept_gap", acc_log[1] - acc_log[0], 222);

        // Asynchronous reset during round 4
        send(c_C1_PT, c_C1_K, c_C1_CT, c_C1_LK);
        g = 0;
        while (!(bus.rc_round == 4'd4 && core_cnt > 5) && g < 400) begin
            tick();
            g++;
        end
        if (g >= 400) tmo("mid_round4_reach");
        resetn = 1'b0;
        #1;
        chk("mid_rst_out_valid", bus.out_valid, 1'b0);
        chk("mid_rst_rc_enable", bus.rc_enable, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        exp_q.delete();
        expk_q.delete();
        acc_q.delete();
        repeat (3) tick();
        resetn = 1'b1;
        tick();
        chk("mid_rst_in_ready", bus.in_ready, 1'b1);
        chk("mid_rst_rc_text", bus.rc_text, '0);
        chk("mid_rst_rc_round", bus.rc_round, '0);
        send(c_C1_PT, c_C1_K, c_C1_CT, c_C1_LK);
        wait_idle("post_rst_timeout");

        repeat (3) tick();
        chki("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual still running required finished");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
